// File: rtl/latency_meter.sv
// ---------------------------------------------------------------------------
// latency_meter
//
// Measures the time from an arm pulse (video flash event) to a sensor
// trigger in prescaled ticks. It reports the raw sample, plus a windowed
// minimum, maximum and average over 2^AVG_LOG2 samples. A measurement that
// runs to TIMEOUT_TICKS without a trigger is abandoned.
//
// All results are binary. Conversion to BCD for the OSD happens downstream.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high
//   start          one-cycle pulse; arms or restarts a measurement
//   sensor_trigger one-cycle pulse; sensor rising edge (detected upstream)
//   clear          one-cycle pulse; clears statistics
//   busy           high while a measurement is running
//   sample_valid   one-cycle pulse; latest holds a freshly captured sample
//   timeout        one-cycle pulse; measurement abandoned
//   latest         last captured sample (MAX_COUNT = no data)
//   minimum        minimum of the current window (MAX_COUNT = no data)
//   maximum        maximum of the current window (0 = no data)
//   average        average of the last completed window (MAX_COUNT = no data)
//   average_valid  one-cycle pulse; average was updated
//   window_fill    samples accumulated in the current window
// ---------------------------------------------------------------------------
module latency_meter #(
  parameter int CLOCK_DIVIDER = 27,
  parameter int COUNT_WIDTH   = 20,
  parameter int MAX_COUNT     = 999999,
  parameter int AVG_LOG2      = 5,
  parameter int TIMEOUT_TICKS = 500000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sensor_trigger,
  input  logic                   clear,
  output logic                   busy,
  output logic                   sample_valid,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] latest,
  output logic [COUNT_WIDTH-1:0] minimum,
  output logic [COUNT_WIDTH-1:0] maximum,
  output logic [COUNT_WIDTH-1:0] average,
  output logic                   average_valid,
  output logic [AVG_LOG2:0]      window_fill
);

  localparam int PRESC_W = $clog2(CLOCK_DIVIDER);
  localparam int ACC_W   = COUNT_WIDTH + AVG_LOG2;
  localparam int FILL_W  = AVG_LOG2 + 1;

  localparam logic [PRESC_W-1:0]     PRESC_LAST  = PRESC_W'(CLOCK_DIVIDER - 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_VAL     = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_TICKS);
  // The fill value at which the next sample completes the window. For
  // AVG_LOG2 = 0 this is 0, so every sample completes its own window.
  localparam logic [FILL_W-1:0]      WIN_LAST    = FILL_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state;
  logic [PRESC_W-1:0]     prescaler;
  logic [COUNT_WIDTH-1:0] elapsed;
  logic [ACC_W-1:0]       accumulator;

  // The elapsed counter stops at MAX_COUNT instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] value
  );
    return (value >= MAX_VAL) ? value : value + COUNT_WIDTH'(1);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] min_of(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [COUNT_WIDTH-1:0] b
  );
    return (b < a) ? b : a;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] max_of(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [COUNT_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  // The window sum cannot exceed 2^AVG_LOG2 * (2^COUNT_WIDTH - 1), so it
  // fits in ACC_W bits. The shifted result fits in COUNT_WIDTH bits.
  // The shift truncates; no rounding is applied.
  function automatic logic [COUNT_WIDTH-1:0] window_average(
    input logic [ACC_W-1:0]       acc,
    input logic [COUNT_WIDTH-1:0] sample
  );
    logic [ACC_W-1:0] total;
    logic [ACC_W-1:0] shifted;
    total   = acc + ACC_W'(sample);
    shifted = total >> AVG_LOG2;
    return shifted[COUNT_WIDTH-1:0];
  endfunction

  // A capture happens when a trigger arrives during a measurement and is
  // not overridden by a restart in the same cycle.
  logic capture;
  assign capture = (state == MEASURE) && sensor_trigger && !start;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      timeout       <= 1'b0;
      average_valid <= 1'b0;
      prescaler     <= '0;
      elapsed       <= '0;
      latest        <= MAX_VAL;
      minimum       <= MAX_VAL;
      maximum       <= '0;
      average       <= MAX_VAL;
      accumulator   <= '0;
      window_fill   <= '0;
    end else begin
      sample_valid  <= 1'b0;
      timeout       <= 1'b0;
      average_valid <= 1'b0;

      // Measurement control
      case (state)
        IDLE: begin
          // Triggers that arrive while idle are deliberately ignored.
          if (start) begin
            state     <= MEASURE;
            busy      <= 1'b1;
            prescaler <= '0;
            elapsed   <= '0;
          end
        end
        MEASURE: begin
          if (start) begin
            // A restart discards the timing in progress. No sample and
            // no timeout are produced.
            prescaler <= '0;
            elapsed   <= '0;
          end else if (sensor_trigger) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sample_valid <= 1'b1;
          end else if (elapsed >= TIMEOUT_VAL) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (prescaler == PRESC_LAST) begin
            prescaler <= '0;
            elapsed   <= sat_inc(elapsed);
          end else begin
            prescaler <= prescaler + PRESC_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Statistics. When clear coincides with a capture, the clear wins
      // and the sample is dropped. sample_valid still pulses from the
      // control path above.
      if (clear) begin
        latest      <= MAX_VAL;
        minimum     <= MAX_VAL;
        maximum     <= '0;
        average     <= MAX_VAL;
        accumulator <= '0;
        window_fill <= '0;
      end else if (capture) begin
        latest <= elapsed;
        if (window_fill == '0) begin
          minimum <= elapsed;
          maximum <= elapsed;
        end else begin
          minimum <= min_of(minimum, elapsed);
          maximum <= max_of(maximum, elapsed);
        end
        if (window_fill == WIN_LAST) begin
          average       <= window_average(accumulator, elapsed);
          average_valid <= 1'b1;
          accumulator   <= '0;
          window_fill   <= '0;
        end else begin
          accumulator <= accumulator + ACC_W'(elapsed);
          window_fill <= window_fill + FILL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_latency_meter.sv
// ---------------------------------------------------------------------------
// tb_latency_meter
//
// Directed bench for latency_meter. It uses two instances:
//   dut_a : CLOCK_DIVIDER=4, AVG_LOG2=2, TIMEOUT_TICKS=64
//           (capture, window statistics, restart, clear)
//   dut_b : CLOCK_DIVIDER=4, AVG_LOG2=0, TIMEOUT_TICKS=8
//           (timeout, trigger-vs-timeout priority, single-sample window)
// With a divider of 4, a trigger sampled 4*v+1 edges after the start edge
// captures the value v.
// ---------------------------------------------------------------------------
module tb_latency_meter;

  localparam int MAXV = 999999;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start_a = 1'b0, trig_a = 1'b0, clear_a = 1'b0;
  logic        busy_a, sv_a, to_a, avv_a;
  logic [19:0] latest_a, min_a, max_a, avg_a;
  logic [2:0]  fill_a;

  logic        start_b = 1'b0, trig_b = 1'b0, clear_b = 1'b0;
  logic        busy_b, sv_b, to_b, avv_b;
  logic [19:0] latest_b, min_b, max_b, avg_b;
  logic [0:0]  fill_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  latency_meter #(
    .CLOCK_DIVIDER(4), .COUNT_WIDTH(20), .MAX_COUNT(MAXV),
    .AVG_LOG2(2), .TIMEOUT_TICKS(64)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .sensor_trigger(trig_a), .clear(clear_a),
    .busy(busy_a), .sample_valid(sv_a), .timeout(to_a),
    .latest(latest_a), .minimum(min_a), .maximum(max_a),
    .average(avg_a), .average_valid(avv_a), .window_fill(fill_a)
  );

  latency_meter #(
    .CLOCK_DIVIDER(4), .COUNT_WIDTH(20), .MAX_COUNT(MAXV),
    .AVG_LOG2(0), .TIMEOUT_TICKS(8)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .sensor_trigger(trig_b), .clear(clear_b),
    .busy(busy_b), .sample_valid(sv_b), .timeout(to_b),
    .latest(latest_b), .minimum(min_b), .maximum(max_b),
    .average(avg_b), .average_valid(avv_b), .window_fill(fill_b)
  );

  // Advance past the next rising edge; outputs are stable afterwards.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Capture value v on dut_a. Returns just after the capture edge.
  task automatic sample_a(input int v);
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (4 * v) tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
  endtask

  task automatic sample_b(input int v);
    start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (4 * v) tick();
    trig_b = 1'b1; tick(); trig_b = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sv_a || to_a || avv_a || sv_b || to_b || avv_b) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL reset_pulses got=%0d want=0", pulses); end
    total++; if (latest_a !== 20'(MAXV)) begin bad++; $display("FAIL reset_latest got=%0d want=%0d", latest_a, MAXV); end
    total++; if (min_a !== 20'(MAXV)) begin bad++; $display("FAIL reset_min got=%0d want=%0d", min_a, MAXV); end
    total++; if (max_a !== 20'd0) begin bad++; $display("FAIL reset_max got=%0d want=0", max_a); end
    total++; if (avg_a !== 20'(MAXV)) begin bad++; $display("FAIL reset_avg got=%0d want=%0d", avg_a, MAXV); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy_a); end
    total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_a); end
  endtask

  task automatic test_single_capture();
    start_a = 1'b1; tick(); start_a = 1'b0;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy_on got=%0d want=1", busy_a); end
    repeat (40) tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    total++; if (sv_a !== 1'b1) begin bad++; $display("FAIL single_valid got=%0d want=1", sv_a); end
    total++; if (latest_a !== 20'd10) begin bad++; $display("FAIL single_latest got=%0d want=10", latest_a); end
    total++; if (min_a !== 20'd10 || max_a !== 20'd10) begin bad++; $display("FAIL single_minmax got=%0d/%0d want=10/10", min_a, max_a); end
    total++; if (fill_a !== 3'd1) begin bad++; $display("FAIL single_fill got=%0d want=1", fill_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_busy_off got=%0d want=0", busy_a); end
    tick();
    total++; if (sv_a !== 1'b0) begin bad++; $display("FAIL single_valid_pulse got=%0d want=0", sv_a); end
  endtask

  task automatic test_window();
    // The window already holds 10 from the single-capture test.
    sample_a(20);
    sample_a(30);
    total++; if (fill_a !== 3'd3 || avv_a !== 1'b0) begin bad++; $display("FAIL win_partial fill=%0d avv=%0d want=3/0", fill_a, avv_a); end
    sample_a(41);
    total++; if (avv_a !== 1'b1) begin bad++; $display("FAIL win_avg_valid got=%0d want=1", avv_a); end
    total++; if (avg_a !== 20'd25) begin bad++; $display("FAIL win_avg got=%0d want=25", avg_a); end
    total++; if (min_a !== 20'd10 || max_a !== 20'd41) begin bad++; $display("FAIL win_minmax got=%0d/%0d want=10/41", min_a, max_a); end
    total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL win_fill_wrap got=%0d want=0", fill_a); end
    sample_a(5);
    total++; if (min_a !== 20'd5 || max_a !== 20'd5) begin bad++; $display("FAIL win_new_minmax got=%0d/%0d want=5/5", min_a, max_a); end
    total++; if (fill_a !== 3'd1 || avg_a !== 20'd25) begin bad++; $display("FAIL win_new_fill fill=%0d avg=%0d want=1/25", fill_a, avg_a); end
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    total++; if (latest_a !== 20'(MAXV) || min_a !== 20'(MAXV) || max_a !== 20'd0 || avg_a !== 20'(MAXV) || fill_a !== 3'd0)
      begin bad++; $display("FAIL clear_idle lat=%0d min=%0d max=%0d avg=%0d fill=%0d", latest_a, min_a, max_a, avg_a, fill_a); end
  endtask

  task automatic test_back_to_back();
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (20) tick();
    start_a = 1'b1; trig_a = 1'b1; tick(); start_a = 1'b0; trig_a = 1'b0;
    total++; if (sv_a !== 1'b0) begin bad++; $display("FAIL restart_no_sample got=%0d want=0", sv_a); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL restart_busy got=%0d want=1", busy_a); end
    repeat (12) tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    total++; if (sv_a !== 1'b1 || latest_a !== 20'd3) begin bad++; $display("FAIL restart_sample sv=%0d lat=%0d want=1/3", sv_a, latest_a); end
    total++; if (min_a !== 20'd3 || max_a !== 20'd3 || fill_a !== 3'd1) begin bad++; $display("FAIL restart_stats min=%0d max=%0d fill=%0d want=3/3/1", min_a, max_a, fill_a); end
  endtask

  task automatic test_clear();
    start_a = 1'b1; tick(); start_a = 1'b0;
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL clear_keeps_busy got=%0d want=1", busy_a); end
    total++; if (fill_a !== 3'd0 || latest_a !== 20'(MAXV)) begin bad++; $display("FAIL clear_midmeasure fill=%0d lat=%0d want=0/%0d", fill_a, latest_a, MAXV); end
    repeat (23) tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    total++; if (latest_a !== 20'd6 || fill_a !== 3'd1 || min_a !== 20'd6 || max_a !== 20'd6)
      begin bad++; $display("FAIL clear_then_sample lat=%0d fill=%0d min=%0d max=%0d want=6/1/6/6", latest_a, fill_a, min_a, max_a); end
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (28) tick();
    trig_a = 1'b1; clear_a = 1'b1; tick(); trig_a = 1'b0; clear_a = 1'b0;
    total++; if (sv_a !== 1'b1) begin bad++; $display("FAIL clearcap_valid got=%0d want=1", sv_a); end
    total++; if (latest_a !== 20'(MAXV)) begin bad++; $display("FAIL clearcap_latest got=%0d want=%0d", latest_a, MAXV); end
    total++; if (fill_a !== 3'd0 || avv_a !== 1'b0) begin bad++; $display("FAIL clearcap_fill fill=%0d avv=%0d want=0/0", fill_a, avv_a); end
    total++; if (min_a !== 20'(MAXV) || max_a !== 20'd0 || avg_a !== 20'(MAXV))
      begin bad++; $display("FAIL clearcap_stats min=%0d max=%0d avg=%0d", min_a, max_a, avg_a); end
  endtask

  task automatic test_timeout();
    int first;
    int count;
    int svs;
    first = -1; count = 0; svs = 0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (to_b) begin
        count++;
        if (first < 0) first = k;
      end
    end
    total++; if (first !== 33) begin bad++; $display("FAIL timeout_cycle got=%0d want=33", first); end
    total++; if (count !== 1) begin bad++; $display("FAIL timeout_once got=%0d want=1", count); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%0d want=0", busy_b); end
    total++; if (latest_b !== 20'(MAXV) || avg_b !== 20'(MAXV) || fill_b !== 1'b0)
      begin bad++; $display("FAIL timeout_stats lat=%0d avg=%0d fill=%0d", latest_b, avg_b, fill_b); end
    trig_b = 1'b1; tick(); trig_b = 1'b0;
    if (sv_b) svs++;
    repeat (3) begin tick(); if (sv_b) svs++; end
    total++; if (svs !== 0 || latest_b !== 20'(MAXV)) begin bad++; $display("FAIL idle_trigger sv=%0d lat=%0d want=0/%0d", svs, latest_b, MAXV); end
  endtask

  task automatic test_trigger_beats_timeout();
    // The trigger lands on the same edge that would otherwise time out.
    sample_b(8);
    total++; if (sv_b !== 1'b1 || to_b !== 1'b0) begin bad++; $display("FAIL trig_vs_to sv=%0d to=%0d want=1/0", sv_b, to_b); end
    total++; if (latest_b !== 20'd8) begin bad++; $display("FAIL trig_vs_to_latest got=%0d want=8", latest_b); end
    total++; if (avv_b !== 1'b1 || avg_b !== 20'd8 || fill_b !== 1'b0)
      begin bad++; $display("FAIL avg1_first avv=%0d avg=%0d fill=%0d want=1/8/0", avv_b, avg_b, fill_b); end
    tick();
    total++; if (to_b !== 1'b0) begin bad++; $display("FAIL trig_vs_to_late got=%0d want=0", to_b); end
    sample_b(3);
    total++; if (avg_b !== 20'd3 || min_b !== 20'd3 || max_b !== 20'd3)
      begin bad++; $display("FAIL avg1_second avg=%0d min=%0d max=%0d want=3/3/3", avg_b, min_b, max_b); end
    sample_b(0);
    total++; if (avg_b !== 20'd0 || avv_b !== 1'b1 || min_b !== 20'd0)
      begin bad++; $display("FAIL zero_sample avg=%0d avv=%0d min=%0d want=0/1/0", avg_b, avv_b, min_b); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_window();
    test_back_to_back();
    test_clear();
    test_timeout();
    test_trigger_beats_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
